// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the FIFO read-side streamer
package fifo_pkg;
    localparam int WIDTH     = 8;
    localparam int OUT_DEPTH = 3;

    typedef logic [1:0] level_t;

    // Circular pointer advance; the depth is not a power of two, so wrap explicitly.
    function automatic level_t ptr_inc(input level_t p);
        return (p == level_t'(OUT_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready output stream of the FIFO read-side streamer
interface fifo_rd_stream_if import fifo_pkg::*; #(parameter int Width = WIDTH);
    logic             m_valid;
    logic             m_ready;
    logic [Width-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/rd_out_buf.sv
// rtl/rd_out_buf.sv - 3-entry circular output buffer with push, pop, head data and occupancy
module rd_out_buf import fifo_pkg::*; #(parameter int Width = WIDTH) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output level_t           occ
);
    logic [Width-1:0] mem [OUT_DEPTH];
    level_t           head;
    level_t           tail;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (occ != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((occ != level_t'(OUT_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (do_pop) begin
                head <= ptr_inc(head);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[head];
endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - issues async-FIFO reads and streams the words out through a small skid buffer
module fifo_rd_stream import fifo_pkg::*; #(parameter int Width = WIDTH) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [Width-1:0]  fifo_rdata,
    output logic              fifo_r_en,
    fifo_rd_stream_if.master  m,
    output level_t            level,
    output logic [15:0]       rd_count
);
    logic             inflight;
    level_t           occ;
    logic             pop;
    logic [Width-1:0] head_data;
    logic [2:0]       committed;

    // Reads are budgeted against buffered plus in-flight words only, so m_ready never reaches fifo_r_en.
    assign committed = {1'b0, occ} + {2'b00, inflight};
    assign fifo_r_en = rrst_n && en && !fifo_empty && !flush && (committed < 3'(OUT_DEPTH));

    assign m.m_valid = (occ != '0) && !flush;
    assign m.m_data  = head_data;
    assign pop       = m.m_valid && m.m_ready;
    assign level     = occ;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (pop) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

    // A word returning during flush is dropped rather than pushed.
    rd_out_buf #(.Width(Width)) u_buf (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .clear     (flush),
        .push      (inflight && !flush),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a behavioural async-FIFO read side
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic        rclk       = 1'b0;
    logic        rrst_n     = 1'b0;
    logic        en         = 1'b0;
    logic        flush      = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = '0;
    logic        fifo_r_en;
    level_t      level;
    logic [15:0] rd_count;

    fifo_rd_stream_if #(.Width(8)) mi ();

    fifo_rd_stream #(.Width(8)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m          (mi),
        .level      (level),
        .rd_count   (rd_count)
    );

    always #5 rclk = ~rclk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic       rd_req    = 1'b0;
    int         rd_issued = 0;

    // FIFO read side: strobe sampled mid-cycle, data presented after the edge.
    always @(negedge rclk) rd_req = fifo_r_en;

    always @(posedge rclk) begin
        if (rd_req) begin
            rd_issued++;
            if (src_q.size() > 0) fifo_rdata <= src_q.pop_front();
            fifo_empty <= (src_q.size() == 0);
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] want;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && mi.m_valid) begin
                tests++;
                if (mi.m_data !== prev_data) begin
                    fails++;
                    $display("FAIL stable_data: got %02h want %02h", mi.m_data, prev_data);
                end
            end
            if (mi.m_valid && mi.m_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %02h want none", mi.m_data);
                end else begin
                    want = exp_q.pop_front();
                    if (mi.m_data !== want) begin
                        fails++;
                        $display("FAIL word_order: got %02h want %02h", mi.m_data, want);
                    end
                end
            end
            prev_stall = mi.m_valid && !mi.m_ready;
            prev_data  = mi.m_data;
        end
    end

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, exp_v);
        end
    endtask

    task automatic preload(input logic [7:0] first, input int n, input bit expect_it);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(first + 8'(i));
            if (expect_it) exp_q.push_back(first + 8'(i));
        end
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            step();
            c++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
    endtask

    int base;
    int cnt0;

    initial begin
        mi.m_ready = 1'b0;
        en         = 1'b1;
        fifo_empty = 1'b0;
        @(negedge rclk);
        check("rst_valid", 32'(mi.m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);
        check("rst_data", 32'(mi.m_data), 32'd0);
        check("rst_r_en", 32'(fifo_r_en), 32'd0);
        fifo_empty = 1'b1;
        step();
        rrst_n = 1'b1;

        // streaming
        mi.m_ready = 1'b1;
        step();
        base = rd_issued;
        preload(8'h01, 8, 1'b1);
        @(negedge rclk);
        check("s1_lat0", 32'(mi.m_valid), 32'd0);
        step();
        @(negedge rclk);
        check("s1_lat1", 32'(mi.m_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge rclk);
            check("s1_stream_valid", 32'(mi.m_valid), 32'd1);
        end
        step();
        @(negedge rclk);
        check("s1_end_valid", 32'(mi.m_valid), 32'd0);
        check("s1_count", 32'(rd_count), 32'd8);
        repeat (3) step();
        check("s1_reads", 32'(rd_issued - base), 32'd8);
        check("s1_r_en_idle", 32'(fifo_r_en), 32'd0);

        // backpressure
        mi.m_ready = 1'b0;
        step();
        base = rd_issued;
        preload(8'h10, 6, 1'b1);
        repeat (8) step();
        @(negedge rclk);
        check("s2_reads", 32'(rd_issued - base), 32'd3);
        check("s2_level", 32'(level), 32'd3);
        check("s2_valid", 32'(mi.m_valid), 32'd1);
        check("s2_head", 32'(mi.m_data), 32'h10);
        repeat (3) step();
        mi.m_ready = 1'b1;
        drain(50);

        // flush with two buffered and one in flight
        mi.m_ready = 1'b0;
        step();
        base = rd_issued;
        cnt0 = 32'(rd_count);
        preload(8'h30, 3, 1'b0);
        preload(8'h33, 3, 1'b1);
        step();
        step();
        step();
        flush = 1'b1;
        @(negedge rclk);
        check("s3_pre_level", 32'(level), 32'd2);
        check("s3_pre_reads", 32'(rd_issued - base), 32'd3);
        check("s3_flush_valid", 32'(mi.m_valid), 32'd0);
        check("s3_flush_r_en", 32'(fifo_r_en), 32'd0);
        step();
        flush = 1'b0;
        @(negedge rclk);
        check("s3_post_level", 32'(level), 32'd0);
        check("s3_post_valid", 32'(mi.m_valid), 32'd0);
        check("s3_count_kept", 32'(rd_count), 32'(cnt0));
        mi.m_ready = 1'b1;
        drain(50);

        // en gating with one read in flight
        mi.m_ready = 1'b1;
        step();
        base = rd_issued;
        cnt0 = 32'(rd_count);
        preload(8'h20, 3, 1'b1);
        step();
        en = 1'b0;
        repeat (6) step();
        @(negedge rclk);
        check("s4_reads", 32'(rd_issued - base), 32'd1);
        check("s4_delivered", 32'(rd_count), 32'(cnt0 + 1));
        check("s4_r_en", 32'(fifo_r_en), 32'd0);
        en = 1'b1;
        drain(50);

        // asynchronous reset mid-stream
        mi.m_ready = 1'b0;
        step();
        preload(8'h40, 3, 1'b0);
        preload(8'h43, 5, 1'b1);
        step();
        step();
        step();
        @(negedge rclk);
        check("s5_pre_level", 32'(level), 32'd2);
        #2;
        rrst_n = 1'b0;
        #1;
        check("s5_rst_valid", 32'(mi.m_valid), 32'd0);
        check("s5_rst_level", 32'(level), 32'd0);
        check("s5_rst_count", 32'(rd_count), 32'd0);
        check("s5_rst_r_en", 32'(fifo_r_en), 32'd0);
        step();
        step();
        rrst_n = 1'b1;
        mi.m_ready = 1'b1;
        drain(50);
        check("s5_count", 32'(rd_count), 32'd5);

        // rd_count wrap
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            src_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        fifo_empty = 1'b0;
        drain(70100);
        check("s6_wrap_count", 32'(rd_count), 32'd4464);
        check("s6_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
